// File: rtl/fcl_fp_seq_pkg.sv
// fcl_fp_seq_pkg
//   Shared types and defaults for the fcl_fp sequencer.
//   Contents: sequencer state enum, default element width / PE count,
//   lane typedef, and a helper that sizes the result shift field.
//   Optional feature macro used by the top: FCL_FP_SEQ_RELU_EN.

package fcl_fp_seq_pkg;

    localparam int FP_WIDTH_DEF    = 16;
    localparam int FP_PARALLEL_DEF = 8;

    typedef enum logic [2:0] {
        S_LOAD  = 3'd0,
        S_RUN   = 3'd1,
        S_FLUSH = 3'd2,
        S_CAPT  = 3'd3,
        S_OUT   = 3'd4
    } state_t;

    typedef logic signed [FP_WIDTH_DEF-1:0] lane_t;

    // The array accumulator is 4x the element width, so the shift field
    // must be able to address any bit of it.
    function automatic int sh_width(input int fp_width);
        return $clog2(4 * fp_width);
    endfunction

    localparam int SH_W_DEF = sh_width(FP_WIDTH_DEF);

endpackage

// File: rtl/fcl_fp_seq_xbuf.sv
// fcl_fp_seq_xbuf
//   Input vector buffer: DEPTH x W storage, one write port, one read port
//   with a registered (1-cycle) read result.
//   Ports:
//     clk, rst           clock, async active-low reset (read register only)
//     we, waddr, wdata   write port
//     re, raddr          read request; rdata valid the following cycle
//     rdata              registered read data

module fcl_fp_seq_xbuf #(
    parameter int W     = 16,
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fcl_fp_seq.sv
// fcl_fp_seq
//   Sequencer/driver for the fcl_fp accumulator array. Buffers one input
//   vector, replays it once per output tile while fetching weight rows,
//   drives the array's accumulate-clear, then captures and streams results.
//   Optional feature: define FCL_FP_SEQ_RELU_EN to clamp negative result
//   lanes to zero at capture.
//   Ports:
//     clk, rst                  clock, async active-low reset
//     cfg_shift                 result right-shift, latched on LOAD->RUN
//     in_valid/in_ready/in_data input element stream
//     w_ren/w_addr/w_rdata      weight memory (rdata 1 cycle after ren)
//     arr_input/arr_w/arr_clr_n/arr_shift   drive to fcl_fp
//     arr_output                results from fcl_fp
//     out_valid/out_ready/out_data/out_tile/out_last  result beats
//     busy                      high whenever not in LOAD
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   LOAD  | accept IN_LEN elements into xbuf
//   RUN   | IN_LEN cycles: read xbuf[k] and weight row tile*IN_LEN+k
//   FLUSH | last element is being fed to the array
//   CAPT  | register array result (optionally ReLU-clamped)
//   OUT   | hold result beat until downstream handshake

module fcl_fp_seq
    import fcl_fp_seq_pkg::*;
#(
    parameter int FP_WIDTH    = FP_WIDTH_DEF,
    parameter int FP_PARALLEL = FP_PARALLEL_DEF,
    parameter int IN_LEN      = 64,
    parameter int N_TILES     = 4,
    parameter int SH_W        = sh_width(FP_WIDTH),
    localparam int AW         = $clog2(IN_LEN * N_TILES),
    localparam int TW         = $clog2(N_TILES) + 1,
    localparam int DW         = FP_PARALLEL * FP_WIDTH
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [SH_W-1:0]     cfg_shift,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [FP_WIDTH-1:0] in_data,
    output logic                w_ren,
    output logic [AW-1:0]       w_addr,
    input  logic [DW-1:0]       w_rdata,
    output logic [FP_WIDTH-1:0] arr_input,
    output logic [DW-1:0]       arr_w,
    output logic                arr_clr_n,
    output logic [SH_W-1:0]     arr_shift,
    input  logic [DW-1:0]       arr_output,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DW-1:0]       out_data,
    output logic [TW-1:0]       out_tile,
    output logic                out_last,
    output logic                busy
);

    localparam int KW = $clog2(IN_LEN);

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q;
    logic [TW-1:0]       tile_q;
    logic [SH_W-1:0]     shift_q;
    logic                feed_vld_q;
    logic                feed_first_q;
    logic [FP_WIDTH-1:0] x_rd;
    logic [DW-1:0]       cap_data;
    logic                k_last;
    logic                tile_last;
    logic                xbuf_we;
    logic                xbuf_re;

    assign k_last    = (k_q == KW'(IN_LEN - 1));
    assign tile_last = (tile_q == TW'(N_TILES - 1));
    assign xbuf_we   = (state_q == S_LOAD) && in_valid;
    assign xbuf_re   = (state_q == S_RUN);

    fcl_fp_seq_xbuf #(
        .W     (FP_WIDTH),
        .DEPTH (IN_LEN),
        .AW    (KW)
    ) u_xbuf (
        .clk   (clk),
        .rst   (rst),
        .we    (xbuf_we),
        .waddr (k_q),
        .wdata (in_data),
        .re    (xbuf_re),
        .raddr (k_q),
        .rdata (x_rd)
    );

    // The array accumulates on every clock, so outside the feed stage all
    // of its operands are forced to zero and clear is held inactive.
    assign arr_input = feed_vld_q ? x_rd    : '0;
    assign arr_w     = feed_vld_q ? w_rdata : '0;
    assign arr_clr_n = ~(feed_vld_q & feed_first_q);
    assign arr_shift = shift_q;

    assign w_addr = (state_q == S_RUN)
                    ? (AW'(tile_q) * AW'(IN_LEN) + AW'(k_q))
                    : '0;

    always_comb begin
        cap_data = arr_output;
`ifdef FCL_FP_SEQ_RELU_EN
        for (int l = 0; l < FP_PARALLEL; l++) begin
            if (arr_output[l*FP_WIDTH + FP_WIDTH - 1]) begin
                cap_data[l*FP_WIDTH +: FP_WIDTH] = '0;
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        in_ready  = 1'b0;
        w_ren     = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state_q)
            S_LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid && k_last) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                w_ren = 1'b1;
                if (k_last) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d = S_OUT;
            end
            S_OUT: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = tile_last ? S_LOAD : S_RUN;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k_q          <= '0;
            tile_q       <= '0;
            shift_q      <= '0;
            feed_vld_q   <= 1'b0;
            feed_first_q <= 1'b0;
            out_data     <= '0;
            out_tile     <= '0;
            out_last     <= 1'b0;
        end else begin
            // Feed stage lags the RUN read by one cycle (xbuf and weight
            // memory both return data the cycle after the request).
            feed_vld_q   <= (state_q == S_RUN);
            feed_first_q <= (state_q == S_RUN) && (k_q == '0);
            case (state_q)
                S_LOAD: begin
                    if (in_valid) begin
                        if (k_last) begin
                            k_q     <= '0;
                            tile_q  <= '0;
                            shift_q <= cfg_shift;
                        end else begin
                            k_q <= k_q + KW'(1);
                        end
                    end
                end
                S_RUN: begin
                    k_q <= k_last ? '0 : k_q + KW'(1);
                end
                S_CAPT: begin
                    out_data <= cap_data;
                    out_tile <= tile_q;
                    out_last <= tile_last;
                end
                S_OUT: begin
                    if (out_ready) begin
                        k_q <= '0;
                        if (!tile_last) begin
                            tile_q <= tile_q + TW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fcl_fp_seq.sv
// tb_fcl_fp_seq
//   Bench for fcl_fp_seq with a behavioural fcl_fp array and weight ROM.
//   IN_LEN=4, FP_PARALLEL=2, N_TILES=2, FP_WIDTH=16.

module tb_fcl_fp_seq;

    localparam int FPW = 16;
    localparam int PAR = 2;
    localparam int L   = 4;
    localparam int NT  = 2;
    localparam int SHW = 6;
    localparam int AW  = 3;
    localparam int TW  = 2;
    localparam int DW  = PAR * FPW;

    logic           clk;
    logic           rst;
    logic [SHW-1:0] cfg_shift;
    logic           in_valid;
    logic           in_ready;
    logic [FPW-1:0] in_data;
    logic           w_ren;
    logic [AW-1:0]  w_addr;
    logic [DW-1:0]  w_rdata;
    logic [FPW-1:0] arr_input;
    logic [DW-1:0]  arr_w;
    logic           arr_clr_n;
    logic [SHW-1:0] arr_shift;
    logic [DW-1:0]  arr_output;
    logic           out_valid;
    logic           out_ready;
    logic [DW-1:0]  out_data;
    logic [TW-1:0]  out_tile;
    logic           out_last;
    logic           busy;

    int checks;
    int failures;

    logic [DW-1:0]        rom [L*NT];
    int                   xv  [L];
    logic signed [63:0]   acc [PAR];
    logic [AW-1:0]        addrq [$];

    fcl_fp_seq #(
        .FP_WIDTH    (FPW),
        .FP_PARALLEL (PAR),
        .IN_LEN      (L),
        .N_TILES     (NT),
        .SH_W        (SHW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_shift  (cfg_shift),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .w_ren      (w_ren),
        .w_addr     (w_addr),
        .w_rdata    (w_rdata),
        .arr_input  (arr_input),
        .arr_w      (arr_w),
        .arr_clr_n  (arr_clr_n),
        .arr_shift  (arr_shift),
        .arr_output (arr_output),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_tile   (out_tile),
        .out_last   (out_last),
        .busy       (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Weight memory: registered read.
    always @(posedge clk) begin
        if (w_ren) w_rdata <= rom[w_addr];
    end

    function automatic logic signed [63:0] sx(input logic [FPW-1:0] v);
        return {{(64-FPW){v[FPW-1]}}, v};
    endfunction

    // Accumulator array: clr_n low loads the product, otherwise adds it.
    always @(posedge clk) begin
        for (int l = 0; l < PAR; l++) begin
            acc[l] <= (arr_clr_n ? acc[l] : 64'sd0)
                      + sx(arr_input) * sx(arr_w[l*FPW +: FPW]);
        end
    end

    always_comb begin
        arr_output = '0;
        for (int l = 0; l < PAR; l++) begin
            arr_output[l*FPW +: FPW] = FPW'(acc[l] >>> arr_shift);
        end
    end

    always @(negedge clk) begin
        if (rst && w_ren) addrq.push_back(w_addr);
    end

    // Expected beat: dot product of the buffered vector with this tile's
    // weight rows, arithmetic right shift, optional ReLU.
    function automatic logic [DW-1:0] ref_beat(input int tile, input int sh);
        logic [DW-1:0]        r;
        longint               s;
        longint               q;
        logic signed [FPW-1:0] wv;
        r = '0;
        for (int l = 0; l < PAR; l++) begin
            s = 0;
            for (int k = 0; k < L; k++) begin
                wv = rom[tile*L + k][l*FPW +: FPW];
                s += longint'(xv[k]) * longint'(wv);
            end
            q = s >>> sh;
            r[l*FPW +: FPW] = FPW'(q);
`ifdef FCL_FP_SEQ_RELU_EN
            if (q < 0) r[l*FPW +: FPW] = '0;
`endif
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive the vector; returns at the negedge of the first RUN cycle.
    task automatic send_vec(input int sh, input bit junk);
        cfg_shift = SHW'(sh);
        for (int k = 0; k < L; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = FPW'(xv[k]);
        end
        @(negedge clk);
        in_valid  = junk;
        in_data   = FPW'($urandom);
        cfg_shift = SHW'($urandom);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) chk("out_valid_timeout", 64'(out_valid), 64'd1);
        in_valid = 1'b0;
    endtask

    task automatic handshake();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic set_unit_rom();
        for (int i = 0; i < L; i++) begin
            rom[i]     = {16'd1, 16'd1};
            rom[L + i] = {16'd2, 16'd2};
        end
    endtask

    initial begin
        int n;
        int base;
        int sh;
        logic [DW-1:0] exp0;
        logic [DW-1:0] exp1;

        checks    = 0;
        failures  = 0;
        rst       = 1'b0;
        cfg_shift = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        set_unit_rom();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Reset state
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_clr_n",     64'(arr_clr_n), 64'd1);
        chk("rst_arr_input", 64'(arr_input), 64'd0);
        chk("rst_busy",      64'(busy),      64'd0);
        chk("rst_w_ren",     64'(w_ren),     64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);

        // x={1,2,3,4}: tile0 w=1 -> 10, tile1 w=2 -> 20; addresses 0..7
        xv = '{1, 2, 3, 4};
        base = addrq.size();
        send_vec(0, 1'b0);
        wait_valid(n);
        chk("t2_latency",  64'(n),        64'd6);
        chk("t2_data0",    64'(out_data), 64'h000A_000A);
        chk("t2_tile0",    64'(out_tile), 64'd0);
        chk("t2_last0",    64'(out_last), 64'd0);
        chk("t2_in_ready", 64'(in_ready), 64'd0);
        handshake();
        chk("t5_in_ready_run", 64'(in_ready), 64'd0);
        wait_valid(n);
        chk("t5_latency1", 64'(n),        64'd6);
        chk("t5_data1",    64'(out_data), 64'h0014_0014);
        chk("t5_tile1",    64'(out_tile), 64'd1);
        chk("t5_last1",    64'(out_last), 64'd1);
        handshake();
        chk("t5_back_load", 64'(in_ready), 64'd1);
        chk("t5_busy",      64'(busy),     64'd0);
        chk("t5_naddr", 64'(addrq.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < addrq.size())
                chk("t5_w_addr", 64'(addrq[base + i]), 64'(i));
        end

        // Negative inputs, shift 2, junk in_valid held during RUN,
        // then a 10-cycle stall in OUT.
        xv = '{-4, -8, -12, -16};
`ifdef FCL_FP_SEQ_RELU_EN
        exp0 = '0;
        exp1 = '0;
`else
        exp0 = 32'hFFF6_FFF6;
        exp1 = 32'hFFEC_FFEC;
`endif
        send_vec(2, 1'b1);
        wait_valid(n);
        chk("t3_latency", 64'(n),         64'd6);
        chk("t3_shift",   64'(arr_shift), 64'd2);
        chk("t3_data0",   64'(out_data),  64'(exp0));
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            chk("t4_hold_data",  64'(out_data),  64'(exp0));
            chk("t4_hold_valid", 64'(out_valid), 64'd1);
            chk("t4_w_ren",      64'(w_ren),     64'd0);
            chk("t4_arr_w",      64'(arr_w),     64'd0);
        end
        handshake();
        wait_valid(n);
        chk("t3_data1", 64'(out_data), 64'(exp1));
        handshake();
        chk("t4_load", 64'(in_ready), 64'd1);

        // Reset in the middle of RUN, then a clean vector
        xv = '{1, 2, 3, 4};
        send_vec(0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("t6_in_ready",  64'(in_ready),  64'd1);
        chk("t6_out_valid", 64'(out_valid), 64'd0);
        chk("t6_w_ren",     64'(w_ren),     64'd0);
        chk("t6_arr_input", 64'(arr_input), 64'd0);
        chk("t6_arr_w",     64'(arr_w),     64'd0);
        chk("t6_clr_n",     64'(arr_clr_n), 64'd1);
        chk("t6_shift",     64'(arr_shift), 64'd0);
        chk("t6_busy",      64'(busy),      64'd0);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        send_vec(0, 1'b0);
        wait_valid(n);
        chk("t6_latency", 64'(n),        64'd6);
        chk("t6_data0",   64'(out_data), 64'h000A_000A);
        handshake();
        wait_valid(n);
        chk("t6_data1",   64'(out_data), 64'h0014_0014);
        handshake();

        // Randomized vectors and weights against the reference model
        for (int it = 0; it < 8; it++) begin
            for (int i = 0; i < L*NT; i++) begin
                for (int l = 0; l < PAR; l++)
                    rom[i][l*FPW +: FPW] = FPW'(int'($urandom_range(100)) - 50);
            end
            for (int k = 0; k < L; k++) xv[k] = int'($urandom_range(200)) - 100;
            sh = int'($urandom_range(7));
            send_vec(sh, 1'($urandom_range(1)));
            for (int t = 0; t < NT; t++) begin
                wait_valid(n);
                chk("rnd_latency", 64'(n), 64'd6);
                repeat ($urandom_range(3)) @(negedge clk);
                chk("rnd_data", 64'(out_data), 64'(ref_beat(t, sh)));
                chk("rnd_tile", 64'(out_tile), 64'(t));
                chk("rnd_last", 64'(out_last), 64'(t == NT - 1));
                handshake();
            end
            chk("rnd_load", 64'(in_ready), 64'd1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
